// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the synchronous
// program memory and presents one instruction per cycle to the decoder.
// Supports free-running fetch, halt and single-step, and redirects on the
// decoder's jump request, squashing the wrong-path instruction as a NOP bubble.
module fetch_unit #(
    parameter int                   PC_WIDTH  = 6,
    parameter int                   INS_WIDTH = 13,
    parameter logic [INS_WIDTH-1:0] NOP_INS   = 13'h1F00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Run,
    input  logic                 Step,
    input  logic [PC_WIDTH:0]    ControlPC,
    output logic [PC_WIDTH-1:0]  PM_Addr,
    input  logic [INS_WIDTH-1:0] PM_Data,
    output logic [INS_WIDTH-1:0] Ins,
    output logic                 InsValid,
    output logic [PC_WIDTH-1:0]  PC,
    output logic                 Halted,
    output logic [15:0]          RetireCnt
);

    typedef enum logic [0:0] {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next sequential address; wraps naturally at the top of program memory.
    function automatic logic [PC_WIDTH-1:0] pc_incr(input logic [PC_WIDTH-1:0] pc_in);
        return pc_in + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Saturating increment for the retire counter.
    function automatic logic [15:0] sat_incr(input logic [15:0] cnt_in);
        logic [15:0] res;
        if (cnt_in == 16'hFFFF) begin
            res = cnt_in;
        end else begin
            res = cnt_in + 16'd1;
        end
        return res;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic                  step_q_r;
    logic                  valid_q_r;
    logic                  squash_q_r;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_next_s;
    logic [15:0]           retire_cnt_r;
    logic [15:0]           retire_next_s;
    logic                  step_edge_s;
    logic                  adv_s;
    logic                  jmp_s;
    logic                  ins_valid_s;

    // A fetched word is real unless the cycle that issued it also retired a jump.
    assign ins_valid_s = valid_q_r & ~squash_q_r;

    // Jump flag only counts when the decoder is looking at a real instruction.
    assign jmp_s = ins_valid_s & ControlPC[PC_WIDTH];

    // State register: reset parks the fetch unit in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HALT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: Run alone decides between HALT and RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (Run) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_RUN: begin
                if (!Run) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_HALT;
            end
        endcase
    end

    // Issue decision: every cycle in RUN, or on a Step rising edge while
    // halted; a concurrent Run request wins and issues from RUN instead.
    always_comb begin
        step_edge_s = Step & ~step_q_r;
        adv_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                adv_s = 1'b1;
            end
            ST_HALT: begin
                if (!Run && step_edge_s) begin
                    adv_s = 1'b1;
                end else begin
                    adv_s = 1'b0;
                end
            end
            default: begin
                adv_s = 1'b0;
            end
        endcase
    end

    // PC selection: a retiring jump wins even while halted so it is not lost.
    always_comb begin
        pc_next_s = pc_r;
        if (jmp_s) begin
            pc_next_s = ControlPC[PC_WIDTH-1:0];
        end else if (adv_s) begin
            pc_next_s = pc_incr(pc_r);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Retire counter advances once per real instruction shown to the decoder.
    always_comb begin
        retire_next_s = retire_cnt_r;
        if (ins_valid_s) begin
            retire_next_s = sat_incr(retire_cnt_r);
        end else begin
            retire_next_s = retire_cnt_r;
        end
    end

    // Pipeline flags, PC, step history and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q_r     <= 1'b0;
            valid_q_r    <= 1'b0;
            squash_q_r   <= 1'b0;
            pc_r         <= {PC_WIDTH{1'b0}};
            retire_cnt_r <= 16'd0;
        end else begin
            step_q_r     <= Step;
            valid_q_r    <= adv_s;
            squash_q_r   <= adv_s & jmp_s;
            pc_r         <= pc_next_s;
            retire_cnt_r <= retire_next_s;
        end
    end

    // Program memory data returns one cycle after the address, so the
    // instruction mux is driven directly by the registered flags.
    assign Ins       = ins_valid_s ? PM_Data : NOP_INS;
    assign InsValid  = ins_valid_s;
    assign PM_Addr   = pc_r;
    assign PC        = pc_r;
    assign Halted    = (state_r == ST_HALT);
    assign RetireCnt = retire_cnt_r;

endmodule
